// File: rtl/deinterleaver_commutator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : deinterleaver_commutator                                      |
// | Brief    : Branch commutator for the convolutional (de)interleaver.      |
// |            Registered 1..NBR branch pointer advancing once per accepted  |
// |            symbol, frame-sync realignment, ascending/descending order,   |
// |            wrap pulse and misaligned-sync detection with saturating      |
// |            error counter.                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module deinterleaver_commutator #(
  parameter int NBR  = 12,  // number of branches, 2..16
  parameter int IDXW = 4    // branch index width, 2**IDXW > NBR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            sync,
  input  logic            mode,
  output logic [IDXW-1:0] sel_idx,
  output logic [NBR-1:0]  sel_oh,
  output logic            sel_vld,
  output logic            wrap,
  output logic            sync_err,
  output logic [7:0]      err_cnt
);

  localparam logic [0:0]      c_st_idle   = 1'b0;
  localparam logic [0:0]      c_st_run    = 1'b1;
  localparam logic [IDXW-1:0] c_idx_first = IDXW'(1);
  localparam logic [IDXW-1:0] c_idx_last  = IDXW'(NBR);
  localparam logic [7:0]      c_cnt_max   = 8'hFF;

  logic [0:0]      state_q,    state_d;
  logic            mode_q,     mode_d;
  logic [IDXW-1:0] sel_idx_q,  sel_idx_d;
  logic [NBR-1:0]  sel_oh_q,   sel_oh_d;
  logic            sel_vld_q,  sel_vld_d;
  logic            wrap_q,     wrap_d;
  logic            sync_err_q, sync_err_d;
  logic [7:0]      err_cnt_q,  err_cnt_d;

  logic            w_on_boundary;
  logic [IDXW-1:0] w_start_idx;

  // A sync is aligned only when the pointer sits on the last branch of the
  // order currently in force; the new start branch follows the incoming mode.
  always_comb begin
    w_on_boundary = mode_q ? (sel_idx_q == c_idx_first) : (sel_idx_q == c_idx_last);
    w_start_idx   = mode ? c_idx_last : c_idx_first;
  end

  // Next-state: FSM, pointer stepping, pulses and error counting.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    sel_idx_d  = sel_idx_q;
    err_cnt_d  = err_cnt_q;
    wrap_d     = 1'b0;
    sync_err_d = 1'b0;

    if (en) begin
      case (state_q)
        c_st_idle: begin
          if (sync) begin
            mode_d    = mode;
            sel_idx_d = w_start_idx;
            state_d   = c_st_run;
          end
        end
        default: begin
          if (sync) begin
            mode_d    = mode;
            sel_idx_d = w_start_idx;
            if (!w_on_boundary) begin
              sync_err_d = 1'b1;
              if (err_cnt_q != c_cnt_max) begin
                err_cnt_d = err_cnt_q + 8'd1;
              end
            end
          end else if (!mode_q) begin
            if (sel_idx_q == c_idx_last) begin
              sel_idx_d = c_idx_first;
              wrap_d    = 1'b1;
            end else begin
              sel_idx_d = sel_idx_q + c_idx_first;
            end
          end else begin
            if (sel_idx_q == c_idx_first) begin
              sel_idx_d = c_idx_last;
              wrap_d    = 1'b1;
            end else begin
              sel_idx_d = sel_idx_q - c_idx_first;
            end
          end
        end
      endcase
    end
  end

  // One-hot and valid are derived from the next index so all three register
  // together and can never disagree.
  always_comb begin
    sel_oh_d = '0;
    for (int i = 0; i < NBR; i++) begin
      sel_oh_d[i] = (sel_idx_d == IDXW'(i + 1));
    end
    sel_vld_d = (sel_idx_d != '0);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= c_st_idle;
      mode_q     <= 1'b0;
      sel_idx_q  <= '0;
      sel_oh_q   <= '0;
      sel_vld_q  <= 1'b0;
      wrap_q     <= 1'b0;
      sync_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      sel_idx_q  <= sel_idx_d;
      sel_oh_q   <= sel_oh_d;
      sel_vld_q  <= sel_vld_d;
      wrap_q     <= wrap_d;
      sync_err_q <= sync_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign sel_idx  = sel_idx_q;
  assign sel_oh   = sel_oh_q;
  assign sel_vld  = sel_vld_q;
  assign wrap     = wrap_q;
  assign sync_err = sync_err_q;
  assign err_cnt  = err_cnt_q;

endmodule
`default_nettype wire
